// File: rtl/enc_32x5_scanner.sv
// Sequential 32-to-5 bit-scan encoder: accepts a vector, then emits one set-bit index per beat.
// Define ENC_MSB_FIRST_EN to scan from the highest set bit down instead of lowest-first.
module enc_32x5_scanner #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] VEC,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [IDX_W-1:0] IDX,
  output logic             LAST,
  output logic             ZERO
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             zero_q, zero_d;
  logic [IDX_W-1:0] scan_idx;
  logic             single_bit;

  // The last matching iteration wins, so the loop direction selects the scan order.
  always_comb begin
    scan_idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (pend_q[i]) scan_idx = IDX_W'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_q[i]) scan_idx = IDX_W'(i);
    end
`endif
  end

  assign single_bit = (pend_q != '0) && ((pend_q & (pend_q - WIDTH'(1))) == '0);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          if (VEC == '0) begin
            zero_d = 1'b1;
          end else begin
            pend_d  = VEC;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (OUT_READY) begin
          pend_d = pend_q & ~(WIDTH'(1) << scan_idx);
          if (single_bit) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

  // All outputs decode from registers; IN_READY is additionally held low during reset.
  assign IN_READY  = (state_q == IDLE) && !RESET;
  assign OUT_VALID = (state_q == SCAN);
  assign IDX       = OUT_VALID ? scan_idx : '0;
  assign LAST      = OUT_VALID && single_bit;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_enc_32x5_scanner.sv
// Self-checking bench for enc_32x5_scanner: queue-based reference model plus directed vectors.
// Honours ENC_MSB_FIRST_EN the same way as the design.
module tb_enc_32x5_scanner;

  logic        CLK;
  logic        RESET;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] VEC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [4:0]  IDX;
  logic        LAST;
  logic        ZERO;

  int n_checks = 0;
  int n_fail   = 0;

  enc_32x5_scanner dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .VEC(VEC),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .IDX(IDX), .LAST(LAST), .ZERO(ZERO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the indices still to be emitted, in emission order.
  int m_q[$];
  bit m_scan = 1'b0;
  bit m_zero = 1'b0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_q.delete();
      m_scan = 1'b0;
      m_zero = 1'b0;
    end else begin
      m_zero = 1'b0;
      if (!m_scan) begin
        if (IN_VALID) begin
          if (VEC == 32'h0) begin
            m_zero = 1'b1;
          end else begin
`ifdef ENC_MSB_FIRST_EN
            for (int i = 31; i >= 0; i--) if (VEC[i]) m_q.push_back(i);
`else
            for (int i = 0; i < 32; i++) if (VEC[i]) m_q.push_back(i);
`endif
            m_scan = 1'b1;
          end
        end
      end else if (OUT_READY) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_scan = 1'b0;
      end
    end
  end

  // Every-cycle compare against the model, mid-cycle.
  always @(negedge CLK) begin
    checkOutput("in_ready",  {31'b0, IN_READY},  {31'b0, (!m_scan && !RESET)});
    checkOutput("out_valid", {31'b0, OUT_VALID}, {31'b0, m_scan});
    checkOutput("idx",       {27'b0, IDX},       m_scan ? m_q[0] : 32'd0);
    checkOutput("last",      {31'b0, LAST},      {31'b0, (m_scan && m_q.size() == 1)});
    checkOutput("zero",      {31'b0, ZERO},      {31'b0, m_zero});
  end

  // Beat log for literal expectations.
  int   beat_idx[$];
  logic beat_last[$];
  int   zero_cnt = 0;

  always @(negedge CLK) begin
    if (OUT_VALID && OUT_READY) begin
      beat_idx.push_back(int'(IDX));
      beat_last.push_back(LAST);
    end
    if (ZERO) zero_cnt++;
  end

  task automatic clearLog();
    beat_idx.delete();
    beat_last.delete();
    zero_cnt = 0;
  endtask

  task automatic applyStimulus(input logic [31:0] v);
    int waited = 0;
    while (!IN_READY && waited < 100) begin
      @(posedge CLK); #2;
      waited++;
    end
    if (!IN_READY) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL send_timeout: in_ready 0 expected 1");
    end
    IN_VALID = 1'b1;
    VEC      = v;
    @(posedge CLK); #2;
    IN_VALID = 1'b0;
  endtask

  task automatic waitIdle();
    int waited = 0;
    while (OUT_VALID && waited < 100) begin
      @(posedge CLK); #2;
      waited++;
    end
    checkOutput("idle_timeout", {31'b0, OUT_VALID}, 32'd0);
  endtask

  initial begin
    int bad;
    int lasts;
    RESET = 1'b0; IN_VALID = 1'b0; VEC = 32'h0; OUT_READY = 1'b1;
    #1 RESET = 1'b1;
    #1;
    checkOutput("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    checkOutput("rst_in_ready",  {31'b0, IN_READY},  32'd0);
    checkOutput("rst_idx",       {27'b0, IDX},       32'd0);
    checkOutput("rst_last",      {31'b0, LAST},      32'd0);
    checkOutput("rst_zero",      {31'b0, ZERO},      32'd0);
    @(posedge CLK); @(posedge CLK); #2;
    RESET = 1'b0;
    @(posedge CLK); #2;

    // 1: single low bit
    clearLog();
    applyStimulus(32'h0000_0001);
    waitIdle();
    checkOutput("t1_count", beat_idx.size(), 32'd1);
    if (beat_idx.size() == 1) begin
      checkOutput("t1_idx",  beat_idx[0], 32'd0);
      checkOutput("t1_last", {31'b0, beat_last[0]}, 32'd1);
    end
    checkOutput("t1_ready", {31'b0, IN_READY}, 32'd1);

    // 2: three bits including bit 31
    clearLog();
    applyStimulus(32'h8000_0011);
    waitIdle();
    checkOutput("t2_count", beat_idx.size(), 32'd3);
    if (beat_idx.size() == 3) begin
`ifdef ENC_MSB_FIRST_EN
      checkOutput("t2_idx0", beat_idx[0], 32'd31);
      checkOutput("t2_idx1", beat_idx[1], 32'd4);
      checkOutput("t2_idx2", beat_idx[2], 32'd0);
`else
      checkOutput("t2_idx0", beat_idx[0], 32'd0);
      checkOutput("t2_idx1", beat_idx[1], 32'd4);
      checkOutput("t2_idx2", beat_idx[2], 32'd31);
`endif
      checkOutput("t2_last", {29'b0, beat_last[0], beat_last[1], beat_last[2]}, 32'b001);
    end

    // 3: backpressure holds the first index
    clearLog();
    OUT_READY = 1'b0;
    applyStimulus(32'h0000_0006);
    repeat (3) begin
      checkOutput("t3_hold_valid", {31'b0, OUT_VALID}, 32'd1);
`ifdef ENC_MSB_FIRST_EN
      checkOutput("t3_hold_idx", {27'b0, IDX}, 32'd2);
`else
      checkOutput("t3_hold_idx", {27'b0, IDX}, 32'd1);
`endif
      checkOutput("t3_hold_last", {31'b0, LAST}, 32'd0);
      @(posedge CLK); #2;
    end
    OUT_READY = 1'b1;
    waitIdle();
    checkOutput("t3_count", beat_idx.size(), 32'd2);
    if (beat_idx.size() == 2) begin
`ifdef ENC_MSB_FIRST_EN
      checkOutput("t3_idx0", beat_idx[0], 32'd2);
      checkOutput("t3_idx1", beat_idx[1], 32'd1);
`else
      checkOutput("t3_idx0", beat_idx[0], 32'd1);
      checkOutput("t3_idx1", beat_idx[1], 32'd2);
`endif
      checkOutput("t3_last", {30'b0, beat_last[0], beat_last[1]}, 32'b01);
    end

    // 4: all-zero vector
    clearLog();
    applyStimulus(32'h0000_0000);
    repeat (3) @(posedge CLK);
    #2;
    checkOutput("t4_zero_pulses", zero_cnt, 32'd1);
    checkOutput("t4_no_beats", beat_idx.size(), 32'd0);
    checkOutput("t4_ready", {31'b0, IN_READY}, 32'd1);

    // Full vector: 32 beats in order, LAST only on the final beat
    clearLog();
    applyStimulus(32'hFFFF_FFFF);
    waitIdle();
    checkOutput("full_count", beat_idx.size(), 32'd32);
    bad = 0;
    lasts = 0;
    foreach (beat_idx[i]) begin
`ifdef ENC_MSB_FIRST_EN
      if (beat_idx[i] != 31 - i) bad++;
`else
      if (beat_idx[i] != i) bad++;
`endif
      if (beat_last[i]) lasts++;
    end
    checkOutput("full_order", bad, 32'd0);
    checkOutput("full_lasts", lasts, 32'd1);
    if (beat_last.size() == 32) checkOutput("full_last_pos", {31'b0, beat_last[31]}, 32'd1);

    // Bit 31 alone
    clearLog();
    applyStimulus(32'h8000_0000);
    waitIdle();
    checkOutput("b31_count", beat_idx.size(), 32'd1);
    if (beat_idx.size() == 1) begin
      checkOutput("b31_idx",  beat_idx[0], 32'd31);
      checkOutput("b31_last", {31'b0, beat_last[0]}, 32'd1);
    end

    // 5: reset mid-scan drops pending bits
    clearLog();
    applyStimulus(32'hFFFF_FFFF);
    repeat (3) @(posedge CLK);
    #2;
    checkOutput("t5_beats_before_rst", beat_idx.size(), 32'd3);
    RESET = 1'b1;
    #1;
    checkOutput("t5_rst_valid", {31'b0, OUT_VALID}, 32'd0);
    checkOutput("t5_rst_ready", {31'b0, IN_READY}, 32'd0);
    @(posedge CLK); #2;
    RESET = 1'b0;
    clearLog();
    applyStimulus(32'h0000_0010);
    waitIdle();
    checkOutput("t5_count", beat_idx.size(), 32'd1);
    if (beat_idx.size() == 1) begin
      checkOutput("t5_idx",  beat_idx[0], 32'd4);
      checkOutput("t5_last", {31'b0, beat_last[0]}, 32'd1);
    end

    repeat (2) @(posedge CLK);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
